// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the iterative AES (Inv)MixColumns block.
// The forward coefficient helpers are only referenced when MIXCOL_FWD_EN is defined.
package inv_mix_columns_iter_pkg;

    typedef logic [7:0]   gf_byte_t;
    typedef logic [31:0]  col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam gf_byte_t AES_POLY = 8'h1b;

    function automatic gf_byte_t xtime(input gf_byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic gf_byte_t gf_mul02(input gf_byte_t x);
        return xtime(x);
    endfunction

    function automatic gf_byte_t gf_mul03(input gf_byte_t x);
        return xtime(x) ^ x;
    endfunction

    function automatic gf_byte_t gf_mul09(input gf_byte_t x);
        gf_byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic gf_byte_t gf_mul0b(input gf_byte_t x);
        gf_byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic gf_byte_t gf_mul0d(input gf_byte_t x);
        gf_byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic gf_byte_t gf_mul0e(input gf_byte_t x);
        gf_byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle between upstream, the (Inv)MixColumns unit and the next decrypt stage.
// The mode signal exists only when MIXCOL_FWD_EN is defined.
interface inv_mix_columns_iter_if;
    import inv_mix_columns_iter_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t data_in;
    logic       out_valid;
    logic       out_ready;
    aes_state_t data_out;
`ifdef MIXCOL_FWD_EN
    logic       mode;
`endif

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
`ifdef MIXCOL_FWD_EN
        , output mode
`endif
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
`ifdef MIXCOL_FWD_EN
        , input mode
`endif
    );

endinterface

// File: rtl/inv_mix_columns_iter_word.sv
// Combinational single-column (Inv)MixColumns; row r of the column sits in bits [8r+7:8r].
// With MIXCOL_FWD_EN defined, i_mode=1 selects the forward matrix through the same rotation network.
module inv_mix_column_word
    import inv_mix_columns_iter_pkg::*;
(
    input  col_t i_col,
`ifdef MIXCOL_FWD_EN
    input  logic i_mode,
`endif
    output col_t o_col
);

    // Byte r of w_rot_k holds row (r+k) mod 4, so each output row reads the same byte lane.
    col_t w_rot1;
    col_t w_rot2;
    col_t w_rot3;

    assign w_rot1 = {i_col[7:0],  i_col[31:8]};
    assign w_rot2 = {i_col[15:0], i_col[31:16]};
    assign w_rot3 = {i_col[23:0], i_col[31:24]};

    always_comb begin
        // NOTE: every combinational output is assigned a default first, so no path can infer a latch.
        o_col = '0;
        for (int r = 0; r < 4; r++) begin
`ifdef MIXCOL_FWD_EN
            if (i_mode) begin
                o_col[8*r +: 8] = gf_mul02(i_col[8*r +: 8])  ^ gf_mul03(w_rot1[8*r +: 8])
                                ^ w_rot2[8*r +: 8]           ^ w_rot3[8*r +: 8];
            end else begin
                o_col[8*r +: 8] = gf_mul0e(i_col[8*r +: 8])  ^ gf_mul0b(w_rot1[8*r +: 8])
                                ^ gf_mul0d(w_rot2[8*r +: 8]) ^ gf_mul09(w_rot3[8*r +: 8]);
            end
`else
            o_col[8*r +: 8] = gf_mul0e(i_col[8*r +: 8])  ^ gf_mul0b(w_rot1[8*r +: 8])
                            ^ gf_mul0d(w_rot2[8*r +: 8]) ^ gf_mul09(w_rot3[8*r +: 8]);
`endif
        end
    end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per clock, 4 clocks per 128-bit state.
// Defining MIXCOL_FWD_EN adds a mode input (latched at accept) that selects forward MixColumns.
module inv_mix_columns_iter
    import inv_mix_columns_iter_pkg::*;
#(
    parameter int NCOLS = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    inv_mix_columns_iter_if.slave  bus
);

    localparam int               COL_W    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    fsm_e             r_state;
    fsm_e             w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic [COL_W-1:0] r_col;
    aes_state_t       r_state_data;
    aes_state_t       r_data_out;
    col_t             w_col_in;
    col_t             w_col_out;
`ifdef MIXCOL_FWD_EN
    logic             r_mode;
`endif

    // Reset asserts asynchronously but releases two clocks later, aligned to sys_clk.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (!sys_rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (r_col == LAST_COL) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gather column r_col: row r lives at byte index NCOLS*r + col.
    always_comb begin
        w_col_in = '0;
        for (int r = 0; r < 4; r++) begin
            w_col_in[8*r +: 8] = r_state_data[8*(NCOLS*r + int'(r_col)) +: 8];
        end
    end

    inv_mix_column_word u_word (
        .i_col  (w_col_in),
`ifdef MIXCOL_FWD_EN
        .i_mode (r_mode),
`endif
        .o_col  (w_col_out)
    );

    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        // NOTE: the data registers are reset too, since data_out must read zero after reset.
        if (!w_rst_n) begin
            r_col        <= '0;
            r_state_data <= '0;
            r_data_out   <= '0;
        end else if (w_accept) begin
            r_col        <= '0;
            r_state_data <= bus.data_in;
        end else if (w_step) begin
            for (int r = 0; r < 4; r++) begin
                r_data_out[8*(NCOLS*r + int'(r_col)) +: 8] <= w_col_out[8*r +: 8];
            end
            r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
        end
    end

`ifdef MIXCOL_FWD_EN
    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_mode <= bus.mode;
        end
    end
`endif

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.data_out  = r_data_out;

endmodule
